// File: rtl/predictor_multislot.sv
// Fetch-stage branch predictor: tagged typed BTB, gshare PHT with speculative
// global history, and a circular return stack, predicting SLOTS instructions per cycle.
module predictor_multislot #(
  parameter int unsigned PC_BITS   = 32,
  parameter int unsigned SLOTS     = 2,
  parameter int unsigned BTB_SIZE  = 256,
  parameter int unsigned PHT_SIZE  = 256,
  parameter int unsigned HIST_BITS = 8,
  parameter int unsigned RAS_DEPTH = 8,
  localparam int unsigned SLOT_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int unsigned RAS_PW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1,
  localparam int unsigned CNT_W    = RAS_PW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_valid,
  input  logic                 fetch_ready,
  input  logic [PC_BITS-1:0]   pc_in,
  output logic                 pred_taken,
  output logic [SLOT_W-1:0]    pred_slot,
  output logic [PC_BITS-1:0]   next_pc,
  output logic [HIST_BITS-1:0] ckpt_ghr,
  output logic [RAS_PW-1:0]    ckpt_ras_ptr,
  output logic [CNT_W-1:0]     ckpt_ras_cnt,
  input  logic                 flush,
  input  logic [HIST_BITS-1:0] flush_ghr,
  input  logic [RAS_PW-1:0]    flush_ras_ptr,
  input  logic [CNT_W-1:0]     flush_ras_cnt,
  input  logic                 upd_valid,
  input  logic [PC_BITS-1:0]   upd_pc,
  input  logic [PC_BITS-1:0]   upd_target,
  input  logic [1:0]           upd_type,
  input  logic                 upd_taken,
  input  logic [HIST_BITS-1:0] upd_ghr,
  input  logic                 inv_valid,
  input  logic [PC_BITS-1:0]   inv_pc
);

  localparam int unsigned BTB_IW = $clog2(BTB_SIZE);
  localparam int unsigned PHT_IW = $clog2(PHT_SIZE);
  localparam int unsigned TAG_W  = PC_BITS - BTB_IW - 2;

  localparam logic [1:0] T_COND = 2'b00;
  localparam logic [1:0] T_CALL = 2'b10;
  localparam logic [1:0] T_RET  = 2'b11;

  logic [BTB_SIZE-1:0] r_btb_valid;
  logic [TAG_W-1:0]    r_btb_tag [BTB_SIZE];
  logic [PC_BITS-1:0]  r_btb_tgt [BTB_SIZE];
  logic [1:0]          r_btb_type[BTB_SIZE];
  logic [1:0]          r_pht     [PHT_SIZE];
  logic [PC_BITS-1:0]  r_ras     [RAS_DEPTH];
  logic [HIST_BITS-1:0] r_ghr;
  logic [RAS_PW-1:0]   r_ras_ptr;
  logic [CNT_W-1:0]    r_ras_cnt;

  logic [PC_BITS-1:0]  w_slot_pc   [SLOTS];
  logic [BTB_IW-1:0]   w_slot_bidx [SLOTS];
  logic [PHT_IW-1:0]   w_slot_pidx [SLOTS];
  logic                w_slot_hit  [SLOTS];
  logic                w_slot_taken[SLOTS];

  // Per-slot BTB/PHT lookup
  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    logic w_unused_lsb;
    assign w_slot_pc[g]    = pc_in + PC_BITS'(4 * g);
    assign w_slot_bidx[g]  = w_slot_pc[g][BTB_IW+1:2];
    assign w_slot_pidx[g]  = w_slot_pc[g][PHT_IW+1:2] ^ PHT_IW'(r_ghr);
    assign w_slot_hit[g]   = r_btb_valid[w_slot_bidx[g]] &&
                             (r_btb_tag[w_slot_bidx[g]] == w_slot_pc[g][PC_BITS-1:BTB_IW+2]);
    assign w_slot_taken[g] = w_slot_hit[g] &&
                             ((r_btb_type[w_slot_bidx[g]] != T_COND) || r_pht[w_slot_pidx[g]][1]);
    assign w_unused_lsb    = ^w_slot_pc[g][1:0];
  end

  logic               w_found;
  logic               w_cond_seen;
  logic [SLOT_W-1:0]  w_win_slot;
  logic [1:0]         w_win_type;
  logic [PC_BITS-1:0] w_win_tgt;
  logic [PC_BITS-1:0] w_win_ret_pc;

  // Lowest taken slot wins; cond hits up to and including the winner drive one history shift
  always_comb begin
    w_found      = 1'b0;
    w_cond_seen  = 1'b0;
    w_win_slot   = '0;
    w_win_type   = T_COND;
    w_win_tgt    = '0;
    w_win_ret_pc = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!w_found) begin
        if (w_slot_hit[i] && (r_btb_type[w_slot_bidx[i]] == T_COND)) w_cond_seen = 1'b1;
        if (w_slot_taken[i]) begin
          w_found      = 1'b1;
          w_win_slot   = SLOT_W'(i);
          w_win_type   = r_btb_type[w_slot_bidx[i]];
          w_win_tgt    = r_btb_tgt[w_slot_bidx[i]];
          w_win_ret_pc = w_slot_pc[i] + PC_BITS'(4);
        end
      end
    end
  end

  logic                 w_ras_nonempty;
  logic                 w_fire;
  logic                 w_push;
  logic                 w_pop;
  logic [RAS_PW-1:0]    w_push_ptr;
  logic [HIST_BITS-1:0] w_ghr_shift;

  assign w_ras_nonempty = (r_ras_cnt != '0);
  assign w_fire         = fetch_valid && fetch_ready && !flush;
  assign w_push         = w_found && (w_win_type == T_CALL);
  assign w_pop          = w_found && (w_win_type == T_RET) && w_ras_nonempty;
  assign w_push_ptr     = r_ras_ptr + RAS_PW'(1);
  assign w_ghr_shift    = HIST_BITS'({r_ghr, (w_found && (w_win_type == T_COND))});

  assign pred_taken   = w_found;
  assign pred_slot    = w_win_slot;
  assign next_pc      = !w_found ? (pc_in + PC_BITS'(4 * SLOTS)) :
                        ((w_win_type == T_RET) && w_ras_nonempty) ? r_ras[r_ras_ptr] : w_win_tgt;
  assign ckpt_ghr     = r_ghr;
  assign ckpt_ras_ptr = r_ras_ptr;
  assign ckpt_ras_cnt = r_ras_cnt;

  // Speculative history and RAS pointer state; flush beats a same-cycle fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr     <= '0;
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (flush) begin
      r_ghr     <= flush_ghr;
      r_ras_ptr <= flush_ras_ptr;
      r_ras_cnt <= flush_ras_cnt;
    end else if (w_fire) begin
      if (w_cond_seen) r_ghr <= w_ghr_shift;
      if (w_push) begin
        r_ras_ptr <= w_push_ptr;
        if (r_ras_cnt != CNT_W'(RAS_DEPTH)) r_ras_cnt <= r_ras_cnt + CNT_W'(1);
      end else if (w_pop) begin
        r_ras_ptr <= r_ras_ptr - RAS_PW'(1);
        r_ras_cnt <= r_ras_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && w_push) r_ras[w_push_ptr] <= w_win_ret_pc;
  end

  logic [BTB_IW-1:0] w_upd_bidx;
  logic [BTB_IW-1:0] w_inv_bidx;
  logic [PHT_IW-1:0] w_upd_pidx;
  logic              w_btb_we;
  logic              w_inv_hit;
  logic              w_unused;

  assign w_upd_bidx = upd_pc[BTB_IW+1:2];
  assign w_inv_bidx = inv_pc[BTB_IW+1:2];
  assign w_upd_pidx = upd_pc[PHT_IW+1:2] ^ PHT_IW'(upd_ghr);
  assign w_btb_we   = upd_valid && (upd_taken || (upd_type != T_COND));
  assign w_inv_hit  = inv_valid && r_btb_valid[w_inv_bidx] &&
                      (r_btb_tag[w_inv_bidx] == inv_pc[PC_BITS-1:BTB_IW+2]);
  assign w_unused   = ^{upd_pc[1:0], inv_pc[1:0]};

  // Valid bits: a same-index write is ordered after the invalidate so it wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btb_valid <= '0;
    end else begin
      if (w_inv_hit) r_btb_valid[w_inv_bidx] <= 1'b0;
      if (w_btb_we)  r_btb_valid[w_upd_bidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_btb_we) begin
      r_btb_tag[w_upd_bidx]  <= upd_pc[PC_BITS-1:BTB_IW+2];
      r_btb_tgt[w_upd_bidx]  <= upd_target;
      r_btb_type[w_upd_bidx] <= upd_type;
    end
  end

  // Saturating 2-bit counters trained at commit with the prediction-time history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_SIZE; i++) r_pht[i] <= 2'b01;
    end else if (upd_valid && (upd_type == T_COND)) begin
      if (upd_taken) begin
        if (r_pht[w_upd_pidx] != 2'b11) r_pht[w_upd_pidx] <= r_pht[w_upd_pidx] + 2'b01;
      end else begin
        if (r_pht[w_upd_pidx] != 2'b00) r_pht[w_upd_pidx] <= r_pht[w_upd_pidx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_predictor_multislot.sv
// Directed bench for predictor_multislot (default parameters: 2 slots, 8-entry RAS).
module tb_predictor_multislot;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid, fetch_ready;
  logic [31:0] pc_in;
  logic        pred_taken;
  logic [0:0]  pred_slot;
  logic [31:0] next_pc;
  logic [7:0]  ckpt_ghr;
  logic [2:0]  ckpt_ras_ptr;
  logic [3:0]  ckpt_ras_cnt;
  logic        flush;
  logic [7:0]  flush_ghr;
  logic [2:0]  flush_ras_ptr;
  logic [3:0]  flush_ras_cnt;
  logic        upd_valid;
  logic [31:0] upd_pc, upd_target;
  logic [1:0]  upd_type;
  logic        upd_taken;
  logic [7:0]  upd_ghr;
  logic        inv_valid;
  logic [31:0] inv_pc;

  int errors = 0;
  int checks = 0;

  predictor_multislot dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .pc_in(pc_in), .pred_taken(pred_taken), .pred_slot(pred_slot), .next_pc(next_pc),
    .ckpt_ghr(ckpt_ghr), .ckpt_ras_ptr(ckpt_ras_ptr), .ckpt_ras_cnt(ckpt_ras_cnt),
    .flush(flush), .flush_ghr(flush_ghr), .flush_ras_ptr(flush_ras_ptr),
    .flush_ras_cnt(flush_ras_cnt), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_type(upd_type), .upd_taken(upd_taken),
    .upd_ghr(upd_ghr), .inv_valid(inv_valid), .inv_pc(inv_pc)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] typ,
                        input logic tk, input logic [7:0] g);
    upd_pc = pc; upd_target = tgt; upd_type = typ; upd_taken = tk; upd_ghr = g;
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic do_flush(input logic [7:0] g, input logic [2:0] p, input logic [3:0] c);
    flush_ghr = g; flush_ras_ptr = p; flush_ras_cnt = c;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_fire(input logic [31:0] pc);
    pc_in = pc; fetch_valid = 1'b1; fetch_ready = 1'b1;
    tick();
    fetch_valid = 1'b0; fetch_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; fetch_valid = 0; fetch_ready = 0; pc_in = 32'h100; flush = 0;
    flush_ghr = 0; flush_ras_ptr = 0; flush_ras_cnt = 0; upd_valid = 0; upd_pc = 0;
    upd_target = 0; upd_type = 0; upd_taken = 0; upd_ghr = 0; inv_valid = 0; inv_pc = 0;
    @(negedge clk); @(negedge clk);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got=%b exp=0", pred_taken); end
    checks++; if (pred_slot !== 1'b0) begin errors++; $display("FAIL reset_slot got=%b exp=0", pred_slot); end
    checks++; if (next_pc !== 32'h108) begin errors++; $display("FAIL reset_next_pc got=%h exp=108", next_pc); end
    checks++; if (ckpt_ghr !== 8'h00) begin errors++; $display("FAIL reset_ghr got=%h exp=00", ckpt_ghr); end
    checks++; if (ckpt_ras_cnt !== 4'd0) begin errors++; $display("FAIL reset_ras_cnt got=%0d exp=0", ckpt_ras_cnt); end
    checks++; if (ckpt_ras_ptr !== 3'd0) begin errors++; $display("FAIL reset_ras_ptr got=%0d exp=0", ckpt_ras_ptr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cond_predict;
    do_upd(32'h104, 32'h200, 2'b00, 1'b1, 8'h00);
    do_upd(32'h104, 32'h200, 2'b00, 1'b1, 8'h00);
    pc_in = 32'h100; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL cond_taken got=%b exp=1", pred_taken); end
    checks++; if (pred_slot !== 1'b1) begin errors++; $display("FAIL cond_slot got=%b exp=1", pred_slot); end
    checks++; if (next_pc !== 32'h200) begin errors++; $display("FAIL cond_next_pc got=%h exp=200", next_pc); end
    do_fire(32'h100);
    checks++; if (ckpt_ghr !== 8'h01) begin errors++; $display("FAIL cond_ghr_taken got=%h exp=01", ckpt_ghr); end
    // history 1 moves the gshare index to an untrained counter
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL cond_ghr1_taken got=%b exp=0", pred_taken); end
    checks++; if (next_pc !== 32'h108) begin errors++; $display("FAIL cond_ghr1_next got=%h exp=108", next_pc); end
    do_fire(32'h100);
    checks++; if (ckpt_ghr !== 8'h02) begin errors++; $display("FAIL cond_ghr_nt got=%h exp=02", ckpt_ghr); end
    do_upd(32'h508, 32'h900, 2'b00, 1'b0, 8'h00);
    pc_in = 32'h508; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL noalloc_taken got=%b exp=0", pred_taken); end
    checks++; if (next_pc !== 32'h510) begin errors++; $display("FAIL noalloc_next got=%h exp=510", next_pc); end
  endtask

  task automatic test_ras_flush;
    do_flush(8'h00, 3'd0, 4'd0);
    do_upd(32'h300, 32'h400, 2'b10, 1'b1, 8'h00);
    do_upd(32'h400, 32'h600, 2'b10, 1'b1, 8'h00);
    do_upd(32'h600, 32'h700, 2'b11, 1'b1, 8'h00);
    pc_in = 32'h300; #1;
    checks++; if (pred_taken !== 1'b1 || pred_slot !== 1'b0) begin errors++; $display("FAIL call1_win got=%b/%b exp=1/0", pred_taken, pred_slot); end
    checks++; if (next_pc !== 32'h400) begin errors++; $display("FAIL call1_next got=%h exp=400", next_pc); end
    do_fire(32'h300);
    pc_in = 32'h400; #1;
    checks++; if (next_pc !== 32'h600) begin errors++; $display("FAIL call2_next got=%h exp=600", next_pc); end
    do_fire(32'h400);
    checks++; if (ckpt_ras_cnt !== 4'd2 || ckpt_ras_ptr !== 3'd2) begin errors++; $display("FAIL calls_ras got=%0d/%0d exp=2/2", ckpt_ras_cnt, ckpt_ras_ptr); end
    pc_in = 32'h600; #1;
    checks++; if (next_pc !== 32'h404) begin errors++; $display("FAIL ret_next got=%h exp=404", next_pc); end
    do_fire(32'h600);
    checks++; if (ckpt_ras_cnt !== 4'd1 || ckpt_ras_ptr !== 3'd1) begin errors++; $display("FAIL ret_ras got=%0d/%0d exp=1/1", ckpt_ras_cnt, ckpt_ras_ptr); end
    do_flush(8'h00, 3'd0, 4'd0);
    checks++; if (ckpt_ras_cnt !== 4'd0 || ckpt_ras_ptr !== 3'd0) begin errors++; $display("FAIL flush_ras got=%0d/%0d exp=0/0", ckpt_ras_cnt, ckpt_ras_ptr); end
    pc_in = 32'h600; #1;
    checks++; if (next_pc !== 32'h700) begin errors++; $display("FAIL ret_empty_next got=%h exp=700", next_pc); end
  endtask

  task automatic test_ras_overflow;
    logic [31:0] exp_pc;
    do_flush(8'h00, 3'd0, 4'd0);
    for (int k = 1; k <= 9; k++) do_upd(32'h1000 + 32'(8 * k), 32'h2100, 2'b10, 1'b1, 8'h00);
    do_upd(32'h2100, 32'h2800, 2'b11, 1'b1, 8'h00);
    for (int k = 1; k <= 9; k++) begin
      do_fire(32'h1000 + 32'(8 * k));
      if (k == 8) begin
        checks++; if (ckpt_ras_cnt !== 4'd8) begin errors++; $display("FAIL ovf_cnt8 got=%0d exp=8", ckpt_ras_cnt); end
      end
    end
    checks++; if (ckpt_ras_cnt !== 4'd8 || ckpt_ras_ptr !== 3'd1) begin errors++; $display("FAIL ovf_sat got=%0d/%0d exp=8/1", ckpt_ras_cnt, ckpt_ras_ptr); end
    for (int j = 1; j <= 9; j++) begin
      exp_pc = (j <= 8) ? (32'h1000 + 32'(8 * (10 - j)) + 32'h4) : 32'h2800;
      pc_in = 32'h2100; #1;
      checks++; if (next_pc !== exp_pc) begin errors++; $display("FAIL ovf_ret%0d got=%h exp=%h", j, next_pc, exp_pc); end
      do_fire(32'h2100);
    end
    checks++; if (ckpt_ras_cnt !== 4'd0 || ckpt_ras_ptr !== 3'd1) begin errors++; $display("FAIL ovf_drain got=%0d/%0d exp=0/1", ckpt_ras_cnt, ckpt_ras_ptr); end
  endtask

  task automatic test_flush_vs_fire;
    do_flush(8'h5A, 3'd0, 4'd0);
    checks++; if (ckpt_ghr !== 8'h5A) begin errors++; $display("FAIL flush_ghr got=%h exp=5a", ckpt_ghr); end
    pc_in = 32'h100; flush_ghr = 8'h33; flush = 1'b1; fetch_valid = 1'b1; fetch_ready = 1'b1;
    tick();
    flush = 1'b0; fetch_valid = 1'b0; fetch_ready = 1'b0;
    checks++; if (ckpt_ghr !== 8'h33) begin errors++; $display("FAIL flush_over_fire got=%h exp=33", ckpt_ghr); end
    do_fire(32'h100);
    checks++; if (ckpt_ghr !== 8'h66) begin errors++; $display("FAIL fire_after_flush got=%h exp=66", ckpt_ghr); end
  endtask

  task automatic test_invalidate;
    do_flush(8'h00, 3'd0, 4'd0);
    pc_in = 32'h100; #1;
    checks++; if (next_pc !== 32'h200) begin errors++; $display("FAIL inv_pre got=%h exp=200", next_pc); end
    inv_pc = 32'h504; inv_valid = 1'b1; tick(); inv_valid = 1'b0; #1;
    checks++; if (next_pc !== 32'h200) begin errors++; $display("FAIL inv_tag_miss got=%h exp=200", next_pc); end
    inv_pc = 32'h104; inv_valid = 1'b1; tick(); inv_valid = 1'b0; #1;
    checks++; if (pred_taken !== 1'b0 || next_pc !== 32'h108) begin errors++; $display("FAIL inv_hit got=%b/%h exp=0/108", pred_taken, next_pc); end
    do_upd(32'h104, 32'h200, 2'b00, 1'b1, 8'h00);
    #1;
    checks++; if (next_pc !== 32'h200) begin errors++; $display("FAIL inv_realloc got=%h exp=200", next_pc); end
    inv_pc = 32'h104; inv_valid = 1'b1;
    upd_pc = 32'h104; upd_target = 32'h280; upd_type = 2'b00; upd_taken = 1'b1; upd_ghr = 8'h00;
    upd_valid = 1'b1;
    tick();
    inv_valid = 1'b0; upd_valid = 1'b0; #1;
    checks++; if (pred_taken !== 1'b1 || next_pc !== 32'h280) begin errors++; $display("FAIL inv_vs_upd got=%b/%h exp=1/280", pred_taken, next_pc); end
  endtask

  task automatic test_reset_mid;
    do_flush(8'h77, 3'd3, 4'd5);
    rst_n = 1'b0; pc_in = 32'h100; #1;
    checks++; if (ckpt_ghr !== 8'h00 || ckpt_ras_ptr !== 3'd0 || ckpt_ras_cnt !== 4'd0) begin errors++; $display("FAIL midrst_state got=%h/%0d/%0d exp=00/0/0", ckpt_ghr, ckpt_ras_ptr, ckpt_ras_cnt); end
    checks++; if (pred_taken !== 1'b0 || next_pc !== 32'h108) begin errors++; $display("FAIL midrst_btb got=%b/%h exp=0/108", pred_taken, next_pc); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_cond_predict();
    test_ras_flush();
    test_ras_overflow();
    test_flush_vs_fire();
    test_invalidate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
